// File: rtl/hazard_unit_pkg.sv
// Shared constants for the hazard unit: opcodes, FSM encoding, perf counter width.
// The perf helper is only referenced when HAZARD_PERF_EN is defined.
package hazard_unit_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_MEMWAIT = 2'b10
  } hz_state_e;

  localparam int unsigned PERF_W = 32;

  function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] v);
    logic [PERF_W-1:0] r;
    if (v == {PERF_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(PERF_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_unit_src_decode.sv
// Combinational source-register decode of an RV32I instruction; shared with the
// forwarding unit so both agree on which operands an opcode actually reads.
module hazard_src_decode
  import hazard_unit_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  logic [6:0] opcode_s;
  logic       unused_s;

  assign opcode_s = inst_i[6:0];
  assign rs1_o    = inst_i[19:15];
  assign rs2_o    = inst_i[24:20];
  assign unused_s = ^{inst_i[31:25], inst_i[14:7]};

  // Operand usage by opcode class
  always_comb begin
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
      end
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      default: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, redirect flush window, memory-wait
// freeze and stall watchdog. HAZARD_PERF_EN adds stall/flush/wait perf counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_inst,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        stall,
  output logic        branch,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        freeze,
  output logic        wdog_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_wait
`endif
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WDOG_LIM8  = 8'(WDOG_LIMIT);

  hz_state_e  state_q, state_d, eff_s;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] wd_q, wd_d, wd_inc_s;
  logic       err_q, err_d, wd_hit_s;

  logic       uses_rs1_s, uses_rs2_s, lu_s;
  logic [4:0] rs1_s, rs2_s;
  logic       stall_s, branch_s, pc_write_s, ifid_write_s, freeze_s;

  hazard_src_decode u_src_decode (
    .inst_i     (id_inst),
    .uses_rs1_o (uses_rs1_s),
    .uses_rs2_o (uses_rs2_s),
    .rs1_o      (rs1_s),
    .rs2_o      (rs2_s)
  );

  assign lu_s = ex_mem_read && (ex_rd != 5'd0) &&
                ((uses_rs1_s && (ex_rd == rs1_s)) || (uses_rs2_s && (ex_rd == rs2_s)));

  // Next state and Mealy controls; a memory wait resumes whatever it interrupted
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_s      = 1'b0;
    branch_s     = 1'b0;
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    freeze_s     = 1'b0;
    if (state_q == ST_MEMWAIT) begin
      eff_s = (cnt_q != 2'd0) ? ST_FLUSH : ST_RUN;
    end else begin
      eff_s = state_q;
    end

    if (mem_busy) begin
      state_d      = ST_MEMWAIT;
      freeze_s     = 1'b1;
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
    end else begin
      case (eff_s)
        ST_FLUSH: begin
          branch_s = 1'b1;
          cnt_d    = ex_redirect ? FLUSH_LOAD : (cnt_q - 2'd1);
          state_d  = (cnt_d == 2'd0) ? ST_RUN : ST_FLUSH;
        end
        default: begin
          cnt_d   = 2'd0;
          state_d = ST_RUN;
          if (ex_redirect) begin
            branch_s = 1'b1;
            cnt_d    = FLUSH_LOAD;
            state_d  = (FLUSH_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
          end else if (lu_s) begin
            stall_s      = 1'b1;
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
          end else begin
            stall_s = 1'b0;
          end
        end
      endcase
    end
  end

  // Watchdog: length of the current stall run including this cycle, saturating
  always_comb begin
    wd_inc_s = (wd_q == 8'hFF) ? wd_q : (wd_q + 8'd1);
    if (stall_s) begin
      wd_d     = wd_inc_s;
      wd_hit_s = (wd_inc_s == WDOG_LIM8);
    end else begin
      wd_d     = 8'd0;
      wd_hit_s = 1'b0;
    end
    err_d = err_q | wd_hit_s;
  end

  // State, flush counter and watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      wd_q    <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced quiet while reset is held, even mid-cycle
  assign stall      = reset & stall_s;
  assign branch     = reset & branch_s;
  assign pc_write   = reset & pc_write_s;
  assign ifid_write = reset & ifid_write_s;
  assign freeze     = reset & freeze_s;
  assign wdog_err   = reset & err_d;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_flush_q, perf_wait_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= {PERF_W{1'b0}};
      perf_flush_q <= {PERF_W{1'b0}};
      perf_wait_q  <= {PERF_W{1'b0}};
    end else begin
      if (stall_s)  perf_stall_q <= perf_sat_inc(perf_stall_q);
      else          perf_stall_q <= perf_stall_q;
      if (branch_s) perf_flush_q <= perf_sat_inc(perf_flush_q);
      else          perf_flush_q <= perf_flush_q;
      if (freeze_s) perf_wait_q  <= perf_sat_inc(perf_wait_q);
      else          perf_wait_q  <= perf_wait_q;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_wait  = perf_wait_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: three hazard_unit copies (FLUSH_CYCLES 1..3) share stimulus
// and are compared every cycle against a rule-level reference model.
module tb_hazard_unit;

  localparam int WDOG = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_inst;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_busy;

  logic [2:0] o_st, o_br, o_pc, o_if, o_fr, o_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] o_ps [3];
  logic [31:0] o_pf [3];
  logic [31:0] o_pw [3];
  int unsigned m_ps [3];
  int unsigned m_pf [3];
  int unsigned m_pw [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_unit #(.FLUSH_CYCLES(g + 1), .WDOG_LIMIT(WDOG)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .id_inst     (id_inst),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .ex_redirect (ex_redirect),
      .mem_busy    (mem_busy),
      .stall       (o_st[g]),
      .branch      (o_br[g]),
      .pc_write    (o_pc[g]),
      .ifid_write  (o_if[g]),
      .freeze      (o_fr[g]),
      .wdog_err    (o_err[g])
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall  (o_ps[g]),
      .perf_flush  (o_pf[g]),
      .perf_wait   (o_pw[g])
`endif
    );
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model: remaining branch cycles, current stall run length, sticky error
  int m_rem [3];
  int m_run [3];
  bit m_err [3];
  bit e_st [3], e_br [3], e_pc [3], e_if [3], e_fr [3], e_err [3];
  int brc [3];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic bit m_lu(logic [31:0] inst, logic mr, logic [4:0] rd);
    logic [6:0] op;
    bit r1, r2;
    op = inst[6:0];
    r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return mr && (rd != 5'd0) && ((r1 && rd == inst[19:15]) || (r2 && rd == inst[24:20]));
  endfunction

  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      {e_st[k], e_br[k], e_pc[k], e_if[k], e_fr[k], e_err[k]} = 6'b0;
      if (reset) begin
        if (mem_busy) e_fr[k] = 1'b1;
        else if (m_rem[k] > 0 || ex_redirect) {e_br[k], e_pc[k], e_if[k]} = 3'b111;
        else if (m_lu(id_inst, ex_mem_read, ex_rd)) e_st[k] = 1'b1;
        else {e_pc[k], e_if[k]} = 2'b11;
        e_err[k] = m_err[k] || (e_st[k] && (m_run[k] + 1 == WDOG));
      end
      chk("stall", k, 32'(o_st[k]), 32'(e_st[k]));
      chk("branch", k, 32'(o_br[k]), 32'(e_br[k]));
      chk("pc_write", k, 32'(o_pc[k]), 32'(e_pc[k]));
      chk("ifid_write", k, 32'(o_if[k]), 32'(e_if[k]));
      chk("freeze", k, 32'(o_fr[k]), 32'(e_fr[k]));
      chk("wdog_err", k, 32'(o_err[k]), 32'(e_err[k]));
`ifdef HAZARD_PERF_EN
      chk("perf_stall", k, o_ps[k], m_ps[k]);
      chk("perf_flush", k, o_pf[k], m_pf[k]);
      chk("perf_wait", k, o_pw[k], m_pw[k]);
`endif
      if (o_br[k]) brc[k]++;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        m_rem[k] = 0;
        m_run[k] = 0;
        m_err[k] = 1'b0;
`ifdef HAZARD_PERF_EN
        m_ps[k] = 0; m_pf[k] = 0; m_pw[k] = 0;
`endif
      end else begin
        m_run[k] = e_st[k] ? m_run[k] + 1 : 0;
        m_err[k] = e_err[k];
        if (!mem_busy) begin
          if (m_rem[k] > 0) m_rem[k] = ex_redirect ? k : m_rem[k] - 1;
          else if (ex_redirect) m_rem[k] = k;
        end
`ifdef HAZARD_PERF_EN
        m_ps[k] += 32'(e_st[k]);
        m_pf[k] += 32'(e_br[k]);
        m_pw[k] += 32'(e_fr[k]);
`endif
      end
    end
    #1;
  endtask

  task automatic idle();
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; mem_busy = 1'b0;
    id_inst = 32'h0000_0013;
  endtask

  localparam logic [31:0] ADD_X6_X5_X7 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_X5       = {7'd0, 5'd5, 5'd5, 3'd0, 5'd5, 7'b0110111};
  localparam logic [31:0] SW_X5        = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] ADDI_RS2F5   = {7'd0, 5'd5, 5'd1, 3'd0, 5'd2, 7'b0010011};

  initial begin
    logic [6:0] ops [9];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_run[k] = 0; m_err[k] = 1'b0; brc[k] = 0;
`ifdef HAZARD_PERF_EN
      m_ps[k] = 0; m_pf[k] = 0; m_pw[k] = 0;
`endif
    end
    reset = 1'b0;
    idle();
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Load-use with dependent ADD, then bubble clears the load
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_inst = ADD_X6_X5_X7;
    cyc();
    ex_mem_read = 1'b0;
    cyc();
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    cyc();
    ex_rd = 5'd5; id_inst = LUI_X5;     cyc();
    id_inst = SW_X5;                    cyc();
    id_inst = ADDI_RS2F5;               cyc();
    id_inst = {7'd0, 5'd5, 5'd1, 3'd0, 5'd0, 7'b1100011}; cyc();

    // Redirect pulse with a load-use hazard present during the window
    idle(); ex_redirect = 1'b1; cyc();
    ex_redirect = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5; id_inst = ADD_X6_X5_X7;
    cyc();
    ex_mem_read = 1'b0; cyc(); cyc();

    // Memory wait inside a flush window
    for (int k = 0; k < 3; k++) brc[k] = 0;
    idle(); ex_redirect = 1'b1; cyc();
    ex_redirect = 1'b0; cyc();
    mem_busy = 1'b1; ex_redirect = 1'b1; cyc(); cyc(); cyc();
    mem_busy = 1'b0; ex_redirect = 1'b0; cyc(); cyc(); cyc();
    for (int k = 0; k < 3; k++) chk("branch_total", k, 32'(brc[k]), 32'(k + 1));

    // Reset asserted mid-flush, then mid-wait
    idle(); ex_redirect = 1'b1; cyc();
    ex_redirect = 1'b0; reset = 1'b0; cyc();
    reset = 1'b1; cyc(); cyc();
    mem_busy = 1'b1; cyc(); cyc();
    reset = 1'b0; cyc();
    reset = 1'b1; mem_busy = 1'b0; cyc();

    // Watchdog: hold the hazard past the limit, then release it
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_inst = ADD_X6_X5_X7;
    for (int i = 0; i < WDOG + 5; i++) cyc();
    idle(); cyc(); cyc();
    for (int k = 0; k < 3; k++) chk("wdog_sticky", k, 32'(o_err[k]), 32'd1);
    reset = 1'b0; cyc();
    reset = 1'b1; cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_inst = $urandom;
      id_inst[6:0] = ops[$urandom_range(0, 8)];
      id_inst[19:15] = 5'($urandom_range(0, 3));
      id_inst[24:20] = 5'($urandom_range(0, 3));
      ex_mem_read = ($urandom_range(0, 1) == 1);
      ex_rd = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 49) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Generates the `stall` and `branch` controls that the ID/EX pipeline register consumes, plus the matching front-end controls (PC write, IF/ID write) and a back-end freeze.
- Sits beside the ID stage. Watches the IF/ID instruction, the EX-stage load/destination info, EX branch/jump resolution and the data-memory busy line.
- A small registered FSM covers multi-cycle flush windows and memory wait. It also runs a stall watchdog.

Parameters:
- FLUSH_CYCLES, default 1: cycles `branch` stays high per redirect, range 1..3.
- WDOG_LIMIT, default 255: consecutive load-use stall cycles before `wdog_err` is set.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_inst  in  32  instruction currently in IF/ID
- ex_mem_read  in  1  ID/EX stage holds a load
- ex_rd  in  5  destination register of the ID/EX instruction (its inst[11:7])
- ex_redirect  in  1  EX resolved a taken branch or a jump this cycle
- mem_busy  in  1  data memory not ready; the whole pipe must hold
- stall  out  1  to ID/EX: insert bubble
- branch  out  1  to ID/EX and IF/ID: squash
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- freeze  out  1  hold EX/MEM and MEM/WB
- wdog_err  out  1  sticky watchdog error

Behaviour:
- Outputs are Mealy: combinational from the registered state and the current inputs. No added latency; the response lands in the same cycle as the cause.
- rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- rs2 is used only by R-type (0110011), S-type (0100011) and B-type (1100011).
- Load-use hazard `lu` = ex_mem_read && ex_rd != 0 && ((rs1 used && ex_rd == id_inst[19:15]) || (rs2 used && ex_rd == id_inst[24:20])).
- FSM states: RUN, FLUSH, MEMWAIT. Reset state is RUN.
- Priority, highest first: reset, mem_busy, flush, lu.
- RUN:
  - mem_busy: go to MEMWAIT. Drive freeze=1, pc_write=0, ifid_write=0, stall=0, branch=0.
  - ex_redirect: drive branch=1, stall=0, pc_write=1, ifid_write=1. Load flush counter with FLUSH_CYCLES-1. If FLUSH_CYCLES>1 go to FLUSH, else stay in RUN.
  - lu: drive stall=1, pc_write=0, ifid_write=0. The bubble clears ex_mem_read next cycle, so a single stall is the normal case.
  - else: pass-through. stall=0, branch=0, pc_write=1, ifid_write=1, freeze=0.
- FLUSH:
  - branch=1 and pc_write=1 (fetch continues from the redirect target); lu is ignored.
  - Counter decrements each cycle; return to RUN when it reaches 0.
  - A new ex_redirect reloads the counter.
  - mem_busy moves to MEMWAIT and saves the remaining count; the flush resumes afterwards.
- MEMWAIT:
  - freeze=1, pc_write=0, ifid_write=0, stall=0, branch=0.
  - On the first cycle with mem_busy low, return to the saved state (RUN or FLUSH) and evaluate normally in that same cycle.
  - ex_redirect is ignored while busy; EX is held, so the redirect is re-presented after the wait.
- Watchdog:
  - 8-bit counter counts consecutive cycles with stall=1 and saturates at 255.
  - It clears on any cycle with stall=0.
  - wdog_err is set when count == WDOG_LIMIT and stays set until reset.
- Reset (asserted at any time, including mid-flush or mid-wait):
  - State RUN, counters 0, wdog_err=0.
  - While reset is low, outputs are stall=0, branch=0, pc_write=0, ifid_write=0, freeze=0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds three 32-bit saturating counters, all cleared by reset, exposed on the outputs perf_stall, perf_flush and perf_wait:
  - perf_stall counts cycles with stall=1.
  - perf_flush counts cycles with branch=1.
  - perf_wait counts cycles with freeze=1.
- Undefined: those ports and counters do not exist; all other behaviour is unchanged.

Decomposition:
- Shared package holds the opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE, OP_STORE, OP_BRANCH), the FSM state encoding (2 bits) and the perf counter width.
- One sub-module, hazard_src_decode: combinational, id_inst to uses_rs1, uses_rs2, rs1, rs2. It is reusable by the forwarding unit.

Test Plan:
- Load then dependent ADD: ex_mem_read=1, ex_rd=5, id_inst=ADD x6,x5,x7 -> stall=1, pc_write=0 for exactly 1 cycle, then pass-through. Same with ex_rd=0 -> no stall.
- Load then LUI x5: ex_rd=5, id_inst opcode 0110111 -> stall=0. S-type with rs2=5 -> stall=1.
- FLUSH_CYCLES=2, ex_redirect pulse -> branch=1 for 2 cycles, pc_write=1 both cycles. Simultaneous lu during the flush -> stall=0.
- mem_busy high 3 cycles in the middle of the FLUSH_CYCLES=3 window -> freeze=1 for 3 cycles, then branch resumes for the remaining count. Total branch-high cycles = 3.
- Hold lu true for 255 cycles with WDOG_LIMIT=255 -> wdog_err=1 on the 255th stall cycle. It stays set after lu drops and clears only on reset.
- Assert reset in FLUSH and in MEMWAIT -> all outputs 0 immediately, state RUN on release. With HAZARD_PERF_EN defined, perf counters read 0 after reset.
